// File: rtl/add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package add_pkg;

  localparam int unsigned NibW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/nib_add4.sv
// Combinational 4-bit adder slice with carry in and carry out.
module nib_add4
  import add_pkg::*;
(
  input  logic [NibW-1:0] a,
  input  logic [NibW-1:0] b,
  input  logic            ci,
  output logic [NibW-1:0] s,
  output logic            co
);

  logic [NibW:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{NibW{1'b0}}, ci};
  assign s   = sum[NibW-1:0];
  assign co  = sum[NibW];

endmodule

// File: rtl/add16_seq.sv
// Sequential adder: one shared 4-bit slice stepped over N_NIB nibbles, LS nibble first.
module add16_seq
  import add_pkg::*;
#(
  parameter int unsigned N_NIB = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NibW*N_NIB-1:0] a,
  input  logic [NibW*N_NIB-1:0] b,
  input  logic                ci,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [NibW*N_NIB-1:0] s,
  output logic                co,
  output logic                ovf
);

  localparam int unsigned W    = NibW * N_NIB;
  localparam int unsigned CntW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
  logic            carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;

  logic [NibW-1:0] nib_a, nib_b, nib_s;
  logic            nib_co;

  assign nib_a = a_q[NibW*int'(cnt_q) +: NibW];
  assign nib_b = b_q[NibW*int'(cnt_q) +: NibW];

  nib_add4 u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        s_d[NibW*int'(cnt_q) +: NibW] = nib_s;
        carry_d = nib_co;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N_NIB - 1)) begin
          state_d = StDone;
          co_d    = nib_co;
          // Carry into the MSB is recovered from the slice's top sum bit.
          ovf_d   = nib_co ^ (nib_a[NibW-1] ^ nib_b[NibW-1] ^ nib_s[NibW-1]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q != StRun);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign s     = s_q;
  assign co    = co_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_add16_seq.sv
// Scoreboard bench for add16_seq: stimulus pushes expected {s, co, ovf}, monitor pops on done.
module tb_add16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ci = 1'b0;
  logic        ready, busy, done, co, ovf;
  logic [15:0] s;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int done_cnt = 0;
  int busy_cycles = 0;
  logic [17:0] exp_q[$];
  int done_times[$];

  add16_seq #(.N_NIB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                        input logic tci);
    logic [16:0] sum;
    logic        v;
    sum = {1'b0, ta} + {1'b0, tb_} + {16'h0, tci};
    v   = (ta[15] == tb_[15]) && (sum[15] != ta[15]);
    return {sum[15:0], sum[16], v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (rst_n && done) begin
      done_cnt++;
      done_times.push_back(cyc_n);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got {s,co,ovf}=0x%0h expected none", {s, co, ovf});
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({s, co, ovf} !== e || ready !== 1'b1) begin
          errors++;
          $display("FAIL result: got {s,co,ovf}=0x%0h ready=%0b expected 0x%0h ready=1",
                   {s, co, ovf}, ready, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tci);
    a = ta;
    b = tb_;
    ci = tci;
    start = 1'b1;
    exp_q.push_back(model(ta, tb_, tci));
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int i;
    for (i = 0; i < 20 && done_cnt < target; i++) cyc();
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d done pulses expected %0d", done_cnt, target);
    end
    cyc();
  endtask

  initial begin
    int base;
    // Reset state
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_co_ovf", 32'({co, ovf}), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Latency: done exactly 4 cycles after acceptance, busy for those 4
    base = done_cnt;
    launch(16'h1234, 16'h4321, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_done_%0d", k), 32'(done), (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("lat_busy_%0d", k), 32'(busy), (k == 4) ? 32'd0 : 32'd1);
    end
    @(posedge clk);
    #1;
    check("idle_after_done", 32'({ready, busy, done}), 32'b100);
    check("hold_s", 32'(s), 32'h5555);

    // Carry and overflow corners
    base = done_cnt;
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(base + 1);
    launch(16'h7FFF, 16'h0000, 1'b1);
    wait_done(base + 2);

    // Start during RUN is ignored
    base = done_cnt;
    busy_cycles = 0;
    launch(16'h0001, 16'h0001, 1'b0);
    cyc();
    a = 16'hAAAA;
    b = 16'h5555;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(base + 1);
    repeat (6) cyc();
    check("run_start_done_cnt", 32'(done_cnt), 32'(base + 1));
    check("run_start_busy_cycles", 32'(busy_cycles), 32'd4);

    // Back-to-back with start held: accepts at cycles 0, 5, 10
    base = done_cnt;
    done_times.delete();
    a = 16'h000F;
    b = 16'h0001;
    ci = 1'b0;
    start = 1'b1;
    repeat (3) exp_q.push_back(model(16'h000F, 16'h0001, 1'b0));
    repeat (12) cyc();
    start = 1'b0;
    wait_done(base + 3);
    repeat (6) cyc();
    check("b2b_done_cnt", 32'(done_cnt), 32'(base + 3));
    if (done_times.size() >= 3) begin
      check("b2b_period_1", 32'(done_times[1] - done_times[0]), 32'd5);
      check("b2b_period_2", 32'(done_times[2] - done_times[1]), 32'd5);
    end

    // Reset mid-RUN: async clear, no done pulse
    base = done_cnt;
    a = 16'h1234;
    b = 16'h1111;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 32'({ready, busy, done}), 32'b100);
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_co_ovf", 32'({co, ovf}), 32'd0);
    repeat (6) cyc();
    check("mid_rst_no_done", 32'(done_cnt), 32'(base));
    rst_n = 1'b1;
    cyc();
    launch(16'h8000, 16'h8000, 1'b0);
    wait_done(base + 1);

    // Random sweep
    base = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      launch(16'($urandom), 16'($urandom), (i % 2 == 0) ? 1'b1 : 1'($urandom));
      wait_done(base + i + 1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
